wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_FU, default 4, number of functional-unit result sources (2..8).
REQ-002 SHALL have parameter NUM_WB, default 2, number of writeback ports (1..NUM_FU).
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, per-FU result buffer entries (power of two, >=2).
REQ-004 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  reset is asynchronous and active-low.
REQ-006 SHALL have port flush  input  1  synchronous discard of all buffered results.
REQ-007 SHALL have port fu_valid  input  NUM_FU  per-FU result offered.
REQ-008 SHALL have port fu_ready  output  NUM_FU  per-FU result accepted this cycle.
REQ-009 SHALL have port fu_data  input  NUM_FU x 32  per-FU result value.
REQ-010 SHALL have port fu_idx  input  NUM_FU x ScoreboardIndex  per-FU scoreboard tag.
REQ-011 SHALL have port wb  output  NUM_WB x writeback_t  writeback ports {valid, idx, data} to scoreboard.
REQ-012 SHALL have port conflict_cnt  output  32  saturating count of cycles with more non-empty FIFOs than NUM_WB.

Function
REQ-013 SHALL hold one FIFO per FU; push when fu_valid[i] & fu_ready[i].
REQ-014 SHALL drive fu_ready[i] = !full[i] & !flush; no push-through when full, even if that FIFO pops in the same cycle.
REQ-015 SHALL take write data, tag and valid for every wb port from FIFO heads only; result pushed at edge t is visible on wb no earlier than cycle t+1.
REQ-016 SHALL treat wb as always accepted: every granted head pops at the next edge.
REQ-017 SHALL grant at most NUM_WB FIFOs per cycle: scan circularly from rr_ptr; the first NUM_WB non-empty FIFOs get grants; the k-th grant drives wb[k].
REQ-018 SHALL set wb[k].valid=0 with idx and data 0 when fewer than k+1 grants exist.
REQ-019 SHALL advance rr_ptr to (last granted FU + 1) mod NUM_FU; rr_ptr unchanged when no grant.
REQ-020 SHALL pop at most one entry per FIFO per cycle; one FU never occupies two wb ports in a cycle.
REQ-021 SHALL keep per-FIFO occupancy 0..FIFO_DEPTH; a simultaneous push and pop leaves it unchanged; pointers wrap mod FIFO_DEPTH.
REQ-022 SHALL on flush: empty all FIFOs at the edge, drop that cycle's fu_valid, force all wb valid=0 that cycle; rr_ptr and conflict_cnt keep their values.
REQ-023 SHALL increment conflict_cnt when the count of non-empty FIFOs exceeds NUM_WB and flush=0; it holds at 0xFFFF_FFFF.
REQ-024 SHALL preserve per-FU order: results of one FU leave in push order.

Reset
REQ-025 SHALL on reset low, asynchronously: empty all FIFOs, rr_ptr=0, conflict_cnt=0, all wb valid/idx/data=0, fu_ready=0.
REQ-026 SHALL drive fu_ready=1 from the first cycle after reset deasserts; reset asserted mid-transfer discards all buffered results with no writeback.

Structure
REQ-027 SHALL take writeback_t, ScoreboardIndex and new constants NumFu, NumWb, WbFifoDepth from OoO_pkg.
REQ-028 SHALL instantiate sub-module wb_fifo (parametrised sync FIFO: push, pop, flush, full, empty, head) once per FU.
REQ-029 SHALL implement the grant scan as combinational logic over NUM_FU with no further sub-modules.

Verification
REQ-030 SHALL cover: NUM_FU=4, NUM_WB=2; FU0 pushes idx=3, data=0x1234 at edge t -> wb[0]={1,3,0x1234} in cycle t+1; wb[1].valid=0.
REQ-031 SHALL cover: all 4 FUs push one result in the same cycle with rr_ptr=0 -> next cycle wb gets FU0,FU1; cycle after gets FU2,FU3; conflict_cnt +1.
REQ-032 SHALL cover: FU2 pushes 3 results with FIFO_DEPTH=2 and no pops allowed -> third cycle fu_ready[2]=0; data order on wb is 1st,2nd,3rd.
REQ-033 SHALL cover: 2 FIFOs hold entries and flush=1 -> wb valid=0 that cycle and the next; occupancy 0; fu_valid during flush never appears on wb.
REQ-034 SHALL cover: FU0 and FU3 continuously non-empty with NUM_WB=1 -> grants alternate 0,3,0,3; rr_ptr wraps 0->1->0 with no starvation.
REQ-035 SHALL cover: reset low while 3 entries are buffered -> all wb valid=0 immediately, conflict_cnt=0, fu_ready=1 the first cycle after release.

Source files
------------

// File: rtl/OoO_pkg.sv
// Shared out-of-order core types and the writeback arbiter defaults.
package OoO_pkg;
  localparam int NumFu       = 4;
  localparam int NumWb       = 2;
  localparam int WbFifoDepth = 2;
  localparam int SbIdxW      = 5;

  typedef logic [SbIdxW-1:0] ScoreboardIndex;

  typedef struct packed {
    logic           valid;
    ScoreboardIndex idx;
    logic [31:0]    data;
  } writeback_t;
endpackage

// File: rtl/wb_fifo.sv
// Per-FU result buffer: power-of-two sync FIFO with flush, head visible combinationally.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_cnt;
  logic             w_push, w_pop;

  assign full   = (r_cnt == (AW+1)'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign head   = r_mem[r_rp];
  assign w_push = push & ~full & ~flush;
  assign w_pop  = pop & ~empty & ~flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wp] <= din;
  end
endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: NUM_FU buffered result sources onto NUM_WB scoreboard ports.
module wb_arbiter
  import OoO_pkg::*;
#(
  parameter int NUM_FU     = NumFu,
  parameter int NUM_WB     = NumWb,
  parameter int FIFO_DEPTH = WbFifoDepth
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [NUM_FU-1:0]            fu_valid,
  output logic [NUM_FU-1:0]            fu_ready,
  input  logic [NUM_FU-1:0][31:0]      fu_data,
  input  ScoreboardIndex [NUM_FU-1:0]  fu_idx,
  output writeback_t [NUM_WB-1:0]      wb,
  output logic [31:0]                  conflict_cnt
);
  localparam int          PW  = $clog2(NUM_FU);
  localparam int          EW  = $bits(ScoreboardIndex) + 32;
  localparam logic [3:0]  WBN = 4'(NUM_WB);

  logic [NUM_FU-1:0]          w_full, w_empty, w_ne, w_push, w_gnt;
  logic [NUM_FU-1:0][EW-1:0]  w_head;
  logic [NUM_FU-1:0][PW-1:0]  w_dist;
  logic [NUM_FU-1:0][3:0]     w_rank;
  logic [3:0]                 w_ne_cnt;
  logic [PW-1:0]              r_rr, w_last, w_ldist, w_rr_nxt;
  logic                       w_any;
  logic [31:0]                r_conflict;

  assign fu_ready     = ~w_full & {NUM_FU{reset & ~flush}};
  assign w_push       = fu_valid & fu_ready;
  assign w_ne         = ~w_empty;
  assign conflict_cnt = r_conflict;

  for (genvar g = 0; g < NUM_FU; g++) begin : g_fifo
    wb_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (w_push[g]),
      .pop   (w_gnt[g]),
      .flush (flush),
      .din   ({fu_idx[g], fu_data[g]}),
      .full  (w_full[g]),
      .empty (w_empty[g]),
      .head  (w_head[g])
    );
  end

  // Scan position of each FU relative to rr_ptr; rank = non-empty FUs ahead of it in the scan.
  always_comb begin
    int d;
    d = 0;
    for (int i = 0; i < NUM_FU; i++) begin
      d = i - int'(r_rr);
      if (d < 0) d = d + NUM_FU;
      w_dist[i] = PW'(d);
    end
  end

  always_comb begin
    w_rank   = '0;
    w_ne_cnt = '0;
    w_gnt    = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      w_ne_cnt = w_ne_cnt + {3'b0, w_ne[i]};
      for (int j = 0; j < NUM_FU; j++) begin
        if (w_ne[j] && (w_dist[j] < w_dist[i])) w_rank[i] = w_rank[i] + 4'd1;
      end
    end
    for (int i = 0; i < NUM_FU; i++) begin
      w_gnt[i] = w_ne[i] & ~flush & (w_rank[i] < WBN);
    end
  end

  always_comb begin
    wb = '0;
    for (int k = 0; k < NUM_WB; k++) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (w_gnt[i] && (w_rank[i] == 4'(k))) begin
          wb[k].valid            = 1'b1;
          {wb[k].idx, wb[k].data} = w_head[i];
        end
      end
    end
  end

  always_comb begin
    w_any   = 1'b0;
    w_last  = '0;
    w_ldist = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (w_gnt[i] && (!w_any || (w_dist[i] > w_ldist))) begin
        w_any   = 1'b1;
        w_last  = PW'(i);
        w_ldist = w_dist[i];
      end
    end
    w_rr_nxt = (w_last == PW'(NUM_FU - 1)) ? '0 : w_last + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rr       <= '0;
      r_conflict <= '0;
    end else begin
      if (w_any) r_rr <= w_rr_nxt;
      if (!flush && (w_ne_cnt > WBN) && (r_conflict != 32'hFFFF_FFFF))
        r_conflict <= r_conflict + 32'd1;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed + random bench for wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;
  import OoO_pkg::*;
  localparam int NF = 4;
  localparam int NW = 2;
  localparam int D  = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  logic [NF-1:0]           fu_valid = '0;
  logic [NF-1:0]           fu_ready;
  logic [NF-1:0][31:0]     fu_data = '0;
  ScoreboardIndex [NF-1:0] fu_idx = '0;
  writeback_t [NW-1:0]     wb;
  logic [31:0]             conflict_cnt;

  logic [NF-1:0]           v1 = '0;
  logic [NF-1:0]           r1;
  logic [NF-1:0][31:0]     d1 = '0;
  ScoreboardIndex [NF-1:0] i1 = '0;
  writeback_t [0:0]        wb1;
  logic [31:0]             c1;

  wb_arbiter #(.NUM_FU(NF), .NUM_WB(NW), .FIFO_DEPTH(D)) dut (
    .clock(clock), .reset(reset), .flush(flush), .fu_valid(fu_valid), .fu_ready(fu_ready),
    .fu_data(fu_data), .fu_idx(fu_idx), .wb(wb), .conflict_cnt(conflict_cnt));

  wb_arbiter #(.NUM_FU(NF), .NUM_WB(1), .FIFO_DEPTH(D)) dut1 (
    .clock(clock), .reset(reset), .flush(flush), .fu_valid(v1), .fu_ready(r1),
    .fu_data(d1), .fu_idx(i1), .wb(wb1), .conflict_cnt(c1));

  always #5 clock = ~clock;

  int nchk = 0;
  int nerr = 0;

  logic [36:0]         mq [NF][$];
  int                  m_rr = 0;
  logic [31:0]         m_cnt = '0;
  logic [NF-1:0]       e_ready;
  writeback_t [NW-1:0] e_wb;
  int                  e_gnt [NW];
  int                  e_ng;
  bit                  track2 = 1'b0;
  logic [31:0]         seen2 [$];
  logic [31:0]         c0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs straight from the arbitration rules, using the queue contents.
  task automatic compute();
    int f;
    e_ready = '0;
    e_wb    = '0;
    e_ng    = 0;
    for (int i = 0; i < NF; i++) e_ready[i] = reset && !flush && (mq[i].size() < D);
    if (reset && !flush) begin
      for (int o = 0; o < NF; o++) begin
        f = (m_rr + o) % NF;
        if (mq[f].size() > 0 && e_ng < NW) begin
          e_gnt[e_ng] = f;
          e_wb[e_ng].valid = 1'b1;
          {e_wb[e_ng].idx, e_wb[e_ng].data} = mq[f][0];
          e_ng++;
        end
      end
    end
  endtask

  task automatic model_edge();
    int ne;
    if (!reset) return;
    if (flush) begin
      for (int i = 0; i < NF; i++) mq[i].delete();
      return;
    end
    ne = 0;
    for (int i = 0; i < NF; i++) if (mq[i].size() > 0) ne++;
    if (ne > NW && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    for (int k = 0; k < e_ng; k++) void'(mq[e_gnt[k]].pop_front());
    for (int i = 0; i < NF; i++)
      if (fu_valid[i] && e_ready[i]) mq[i].push_back({fu_idx[i], fu_data[i]});
    if (e_ng > 0) m_rr = (e_gnt[e_ng-1] + 1) % NF;
  endtask

  task automatic settle();
    #1;
    compute();
    chk("fu_ready", 64'(fu_ready), 64'(e_ready));
    for (int k = 0; k < NW; k++) chk($sformatf("wb%0d", k), 64'(wb[k]), 64'(e_wb[k]));
    chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
    if (track2)
      for (int k = 0; k < NW; k++)
        if (wb[k].valid && wb[k].data[31:4] == 28'h000000B) seen2.push_back(wb[k].data);
  endtask

  task automatic advance();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic idle();
    fu_valid = '0;
    flush    = 1'b0;
  endtask

  task automatic drive_rand();
    for (int i = 0; i < NF; i++) begin
      fu_data[i] = $urandom;
      fu_idx[i]  = ScoreboardIndex'($urandom);
    end
    fu_valid = NF'($urandom);
    flush    = ($urandom_range(15) == 0);
  endtask

  task automatic do_reset();
    #3 reset = 1'b0;
    #1;
    chk("rst_wb0", 64'(wb[0]), 64'd0);
    chk("rst_wb1", 64'(wb[1]), 64'd0);
    chk("rst_cnt", 64'(conflict_cnt), 64'd0);
    chk("rst_ready", 64'(fu_ready), 64'd0);
    for (int i = 0; i < NF; i++) mq[i].delete();
    m_rr  = 0;
    m_cnt = '0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    #1;
    chk("init_ready", 64'(fu_ready), 64'd0);
    chk("init_wb0", 64'(wb[0]), 64'd0);
    chk("init_wb1", 64'(wb[1]), 64'd0);
    chk("init_cnt", 64'(conflict_cnt), 64'd0);
    chk("init_wb_n1", 64'(wb1[0]), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    idle(); settle(); chk("ready_after_rst", 64'(fu_ready), 64'hF); advance();

    // single result from FU0 appears one cycle after its push
    fu_valid = 4'b0001; fu_idx[0] = 5'd3; fu_data[0] = 32'h1234;
    settle(); chk("no_passthru", 64'(wb[0].valid), 64'd0); advance();
    idle(); settle();
    chk("single_wb0", 64'(wb[0]), 64'({1'b1, 5'd3, 32'h1234}));
    chk("single_wb1_v", 64'(wb[1].valid), 64'd0);
    advance();

    // grant FU3 so the pointer wraps back to 0
    fu_valid = 4'b1000; fu_data[3] = $urandom; settle(); advance();
    idle(); settle(); advance();

    // all four push together: FU0/FU1 then FU2/FU3, one conflict cycle
    c0 = m_cnt;
    fu_valid = 4'hF;
    for (int i = 0; i < NF; i++) begin
      fu_data[i] = 32'hA000_0000 + 32'(i);
      fu_idx[i]  = ScoreboardIndex'(i + 8);
    end
    settle(); advance();
    idle(); settle();
    chk("all4_c1_wb0", 64'(wb[0].data), 64'h A000_0000);
    chk("all4_c1_wb1", 64'(wb[1].data), 64'h A000_0001);
    advance();
    settle();
    chk("all4_c2_wb0", 64'(wb[0].data), 64'h A000_0002);
    chk("all4_c2_wb1", 64'(wb[1].data), 64'h A000_0003);
    chk("all4_conflict", 64'(conflict_cnt), 64'(c0 + 32'd1));
    advance();
    settle(); advance();

    // FU2 fills its FIFO while the other FUs win the ports
    track2 = 1'b1;
    fu_valid = 4'hF;
    for (int i = 0; i < NF; i++) fu_data[i] = 32'hC000_0000 + 32'(i);
    fu_data[2] = 32'hB1; settle(); advance();
    fu_data[2] = 32'hB2; settle(); advance();
    fu_valid = 4'b0100; fu_data[2] = 32'hB3;
    settle(); chk("fu2_full_ready", 64'(fu_ready[2]), 64'd0); advance();
    settle(); chk("fu2_ready_again", 64'(fu_ready[2]), 64'd1); advance();
    idle();
    for (int n = 0; n < 4; n++) begin settle(); advance(); end
    track2 = 1'b0;
    chk("fu2_seen_n", 64'(seen2.size()), 64'd3);
    if (seen2.size() == 3) begin
      chk("fu2_ord0", 64'(seen2[0]), 64'hB1);
      chk("fu2_ord1", 64'(seen2[1]), 64'hB2);
      chk("fu2_ord2", 64'(seen2[2]), 64'hB3);
    end

    // flush with two FIFOs occupied; results offered during flush are dropped
    fu_valid = 4'b0011; fu_data[0] = 32'h11; fu_data[1] = 32'h22; settle(); advance();
    fu_valid = 4'b0011; fu_data[0] = 32'h33; fu_data[1] = 32'h44; settle(); advance();
    flush = 1'b1; fu_valid = 4'hF;
    for (int i = 0; i < NF; i++) fu_data[i] = 32'hDEAD_0000 + 32'(i);
    settle();
    chk("flush_v0", 64'(wb[0].valid), 64'd0);
    chk("flush_v1", 64'(wb[1].valid), 64'd0);
    chk("flush_ready", 64'(fu_ready), 64'd0);
    advance();
    idle(); settle();
    chk("postflush_v0", 64'(wb[0].valid), 64'd0);
    chk("postflush_v1", 64'(wb[1].valid), 64'd0);
    advance();

    // single port: FU0 and FU3 alternate without starvation
    v1 = 4'b1001; d1[0] = 32'd0; d1[3] = 32'd3;
    settle(); advance();
    for (int n = 0; n < 8; n++) begin
      settle();
      chk($sformatf("rr1_v%0d", n), 64'(wb1[0].valid), 64'd1);
      chk($sformatf("rr1_fu%0d", n), 64'(wb1[0].data), (n % 2 == 1) ? 64'd3 : 64'd0);
      advance();
    end
    v1 = '0;

    // reset mid-transfer with three results buffered
    fu_valid = 4'b0111; settle(); advance();
    idle();
    do_reset();
    settle(); chk("rel_ready", 64'(fu_ready), 64'hF); advance();
    settle(); chk("rel_nowb", 64'(wb[0].valid), 64'd0); advance();

    for (int n = 0; n < 600; n++) begin
      if (n % 200 == 199) do_reset();
      drive_rand();
      settle();
      advance();
    end
    idle(); settle();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
